// File: rtl/ticket_pkg.sv
// Shared types and constants for the change dispenser.
// Coin denominations, FSM state encoding and the default money width.
package ticket_pkg;

    localparam int MONEY_W = 7;
    localparam int COIN_W  = 4;

    localparam int unsigned COIN_10 = 10;
    localparam int unsigned COIN_5  = 5;
    localparam int unsigned COIN_1  = 1;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        DISPENSE,
        DONE,
        ERR
    } dispense_state_t;

    function automatic logic [3:0] sat_inc4(input logic [3:0] value);
        return (value == 4'hF) ? value : value + 4'd1;
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Coin hopper handshake: one coin per valid/ready transfer.
// The dispenser drives the master side, the hopper the slave side.
interface change_dispenser_if #(
    parameter int COIN_W = 4
);
    logic              coin_valid;
    logic [COIN_W-1:0] coin_value;
    logic              coin_ready;

    modport master (output coin_valid, output coin_value, input coin_ready);
    modport slave  (input coin_valid, input coin_value, output coin_ready);
endinterface

// File: rtl/change_dispenser_coin_selector.sv
// Picks the largest coin that fits the outstanding change; 0 when nothing is owed.
module coin_selector #(
    parameter int MONEY_W = 7,
    parameter int COIN_W  = 4
) (
    input  logic [MONEY_W-1:0] amount,
    output logic [COIN_W-1:0]  coin
);
    import ticket_pkg::*;

    always_comb begin
        coin = '0;
        if (amount >= MONEY_W'(COIN_10)) begin
            coin = COIN_W'(COIN_10);
        end else if (amount >= MONEY_W'(COIN_5)) begin
            coin = COIN_W'(COIN_5);
        end else if (amount != '0) begin
            coin = COIN_W'(COIN_1);
        end
    end
endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: computes paid-cost and pays it out largest coin first.
// Optional per-denomination coin counters when COIN_COUNT_EN is defined.
//
// state    | meaning
// IDLE     | waiting for start, operands captured on start
// CALC     | compare operands, load change_left
// DISPENSE | present coins to the hopper until change_left reaches 0
// DONE     | one-cycle done pulse
// ERR      | one-cycle underpaid pulse
module change_dispenser #(
    parameter int MONEY_W = ticket_pkg::MONEY_W,
    parameter int COIN_W  = ticket_pkg::COIN_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [MONEY_W-1:0]   total_paid,
    input  logic [MONEY_W-1:0]   total_cost,
    change_dispenser_if.master   coin,
    output logic [MONEY_W-1:0]   change_left,
    output logic                 busy,
    output logic                 done,
    output logic                 underpaid
`ifdef COIN_COUNT_EN
    ,
    output logic [3:0]           cnt10,
    output logic [3:0]           cnt5,
    output logic [3:0]           cnt1
`endif
);
    import ticket_pkg::*;

    dispense_state_t    state, state_next;
    logic [MONEY_W-1:0] paid_q, cost_q;
    logic [COIN_W-1:0]  sel_coin;
    logic               handshake;

    coin_selector #(
        .MONEY_W (MONEY_W),
        .COIN_W  (COIN_W)
    ) u_coin_selector (
        .amount (change_left),
        .coin   (sel_coin)
    );

    assign handshake = (state == DISPENSE) && coin.coin_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        coin.coin_valid = 1'b0;
        coin.coin_value = '0;
        busy            = 1'b1;
        done            = 1'b0;
        underpaid       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                if (paid_q < cost_q) begin
                    state_next = ERR;
                end else if (paid_q == cost_q) begin
                    state_next = DONE;
                end else begin
                    state_next = DISPENSE;
                end
            end
            DISPENSE: begin
                coin.coin_valid = 1'b1;
                coin.coin_value = sel_coin;
                // Last coin: the remaining change equals the coin being taken.
                if (handshake && (change_left == MONEY_W'(sel_coin))) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            ERR: begin
                underpaid  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            paid_q      <= '0;
            cost_q      <= '0;
            change_left <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        paid_q <= total_paid;
                        cost_q <= total_cost;
                    end
                end
                CALC: begin
                    if (paid_q > cost_q) begin
                        change_left <= paid_q - cost_q;
                    end else begin
                        change_left <= '0;
                    end
                end
                DISPENSE: begin
                    if (handshake) begin
                        change_left <= change_left - MONEY_W'(sel_coin);
                    end
                end
                ERR: begin
                    change_left <= '0;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef COIN_COUNT_EN
    // Counts stay visible after DONE and clear only when a new transaction starts.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt10 <= '0;
            cnt5  <= '0;
            cnt1  <= '0;
        end else if ((state == IDLE) && start) begin
            cnt10 <= '0;
            cnt5  <= '0;
            cnt1  <= '0;
        end else if (handshake) begin
            if (sel_coin == COIN_W'(COIN_10)) begin
                cnt10 <= sat_inc4(cnt10);
            end else if (sel_coin == COIN_W'(COIN_5)) begin
                cnt5 <= sat_inc4(cnt5);
            end else if (sel_coin == COIN_W'(COIN_1)) begin
                cnt1 <= sat_inc4(cnt1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: vector table plus reset-in-flight sequence.
module tb_change_dispenser;

    localparam int MONEY_W = 7;
    localparam int COIN_W  = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [MONEY_W-1:0] total_paid, total_cost;
    logic [MONEY_W-1:0] change_left;
    logic               busy, done, underpaid;
`ifdef COIN_COUNT_EN
    logic [3:0]         cnt10, cnt5, cnt1;
`endif

    change_dispenser_if #(.COIN_W(COIN_W)) coin_bus ();

    change_dispenser #(
        .MONEY_W (MONEY_W),
        .COIN_W  (COIN_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .total_paid  (total_paid),
        .total_cost  (total_cost),
        .coin        (coin_bus),
        .change_left (change_left),
        .busy        (busy),
        .done        (done),
        .underpaid   (underpaid)
`ifdef COIN_COUNT_EN
        ,
        .cnt10       (cnt10),
        .cnt5        (cnt5),
        .cnt1        (cnt1)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [MONEY_W-1:0] paid;
        logic [MONEY_W-1:0] cost;
        int stall;
        int busy_start;
        int exp_change;
        int exp_n10;
        int exp_n5;
        int exp_n1;
        int exp_done_cyc;
        int exp_under_cyc;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int n10 = 0, n5 = 0, n1 = 0;
        int done_cyc = 0, under_cyc = 0, first_coin = 0;
        int change_c2 = -1, busy_c1 = 0;
        int order_bad = 0, zero_bad = 0, stall_bad = 0, idle_busy = 0;
        int stall_left, last_coin, prev_val, exp_first;
        bit prev_stalled;
        stall_left   = v.stall;
        last_coin    = 99;
        prev_val     = 0;
        prev_stalled = 0;
        exp_first    = (v.exp_n10 + v.exp_n5 + v.exp_n1 > 0) ? 2 : 0;

        @(negedge clk);
        total_paid = v.paid;
        total_cost = v.cost;
        start      = 1'b1;
        coin_bus.coin_ready = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        total_paid = '0;
        total_cost = '0;

        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (c == 1) busy_c1 = int'(busy);
            if (c == 2) change_c2 = int'(change_left);
            if (!coin_bus.coin_valid && coin_bus.coin_value != '0) zero_bad++;
            if (prev_stalled && (!coin_bus.coin_valid || int'(coin_bus.coin_value) != prev_val))
                stall_bad++;
            prev_stalled = 0;
            if (done) begin
                done_cyc = c;
                break;
            end
            if (underpaid) begin
                under_cyc = c;
                break;
            end
            if (coin_bus.coin_valid) begin
                if (first_coin == 0) first_coin = c;
                if (stall_left > 0) begin
                    coin_bus.coin_ready = 1'b0;
                    stall_left--;
                    prev_stalled = 1;
                    prev_val = int'(coin_bus.coin_value);
                end else begin
                    coin_bus.coin_ready = 1'b1;
                    if (int'(coin_bus.coin_value) > last_coin) order_bad++;
                    last_coin = int'(coin_bus.coin_value);
                    case (int'(coin_bus.coin_value))
                        10:      n10++;
                        5:       n5++;
                        1:       n1++;
                        default: order_bad++;
                    endcase
                end
            end else begin
                coin_bus.coin_ready = 1'b1;
            end
            // Start pulsed mid-transaction with junk operands must be ignored.
            start = (c == v.busy_start);
            total_paid = start ? 7'd99 : '0;
            total_cost = '0;
        end
        start = 1'b0;
        total_paid = '0;

        @(negedge clk);
        check($sformatf("v%0d_busy_calc", idx), busy_c1, 1);
        check($sformatf("v%0d_change_first", idx), change_c2, v.exp_change);
        check($sformatf("v%0d_first_coin_cyc", idx), first_coin, exp_first);
        check($sformatf("v%0d_done_cyc", idx), done_cyc, v.exp_done_cyc);
        check($sformatf("v%0d_underpaid_cyc", idx), under_cyc, v.exp_under_cyc);
        check($sformatf("v%0d_n10", idx), n10, v.exp_n10);
        check($sformatf("v%0d_n5", idx), n5, v.exp_n5);
        check($sformatf("v%0d_n1", idx), n1, v.exp_n1);
        check($sformatf("v%0d_order", idx), order_bad, 0);
        check($sformatf("v%0d_value_zero_when_idle", idx), zero_bad, 0);
        check($sformatf("v%0d_stall_stable", idx), stall_bad, 0);
        check($sformatf("v%0d_pulse_one_cycle", idx), int'(done) + int'(underpaid), 0);
        check($sformatf("v%0d_change_end", idx), int'(change_left), 0);
`ifdef COIN_COUNT_EN
        check($sformatf("v%0d_cnt10", idx), int'(cnt10), v.exp_n10);
        check($sformatf("v%0d_cnt5", idx), int'(cnt5), v.exp_n5);
        check($sformatf("v%0d_cnt1", idx), int'(cnt1), v.exp_n1);
`endif
        for (int k = 0; k < 4; k++) begin
            if (busy || coin_bus.coin_valid) idle_busy++;
            @(negedge clk);
        end
        check($sformatf("v%0d_idle_after", idx), idle_busy, 0);
    endtask

    initial begin
        int bad_cycles;
        //          paid  cost stall bstart chg n10 n5 n1 done under
        vecs[0] = '{7'd26,  7'd10, 0, 0, 16,  1, 1, 1,  5, 0};
        vecs[1] = '{7'd20,  7'd14, 3, 0,  6,  0, 1, 1,  7, 0};
        vecs[2] = '{7'd15,  7'd15, 0, 0,  0,  0, 0, 0,  2, 0};
        vecs[3] = '{7'd9,   7'd16, 0, 0,  0,  0, 0, 0,  0, 2};
        vecs[4] = '{7'd127, 7'd0,  0, 0, 127, 12, 1, 2, 17, 0};
        vecs[5] = '{7'd26,  7'd10, 0, 3, 16,  1, 1, 1,  5, 0};
        vecs[6] = '{7'd4,   7'd0,  1, 0,  4,  0, 0, 4,  7, 0};
        vecs[7] = '{7'd100, 7'd95, 0, 0,  5,  0, 1, 0,  3, 0};

        reset = 1'b0;
        start = 1'b0;
        total_paid = '0;
        total_cost = '0;
        coin_bus.coin_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", int'(coin_bus.coin_valid) + int'(coin_bus.coin_value) +
              int'(change_left) + int'(busy) + int'(done) + int'(underpaid), 0);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_vec(i, vecs[i]);
        end

        // Reset while coins are still being paid out.
        @(negedge clk);
        total_paid = 7'd127;
        total_cost = 7'd0;
        start = 1'b1;
        coin_bus.coin_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("midreset_dispensing", int'(coin_bus.coin_valid), 1);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midreset_valid", int'(coin_bus.coin_valid), 0);
        check("midreset_value", int'(coin_bus.coin_value), 0);
        check("midreset_change", int'(change_left), 0);
        check("midreset_flags", int'(busy) + int'(done) + int'(underpaid), 0);
`ifdef COIN_COUNT_EN
        check("midreset_counters", int'(cnt10) + int'(cnt5) + int'(cnt1), 0);
`endif
        reset = 1'b1;
        bad_cycles = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done || busy || coin_bus.coin_valid) bad_cycles++;
        end
        check("midreset_no_done", bad_cycles, 0);

        run_vec(8, vecs[7]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
